// File: rtl/boot_pkg.sv
// Boot loader shared types: FSM state enum, default frame marker,
// length and checksum widths. BOOT_CHECKSUM_EN adds the CSUM state.
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         LEN_W         = 16;
  localparam int         CSUM_W        = 8;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
`ifdef BOOT_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/boot_ctrl.sv
// Boot loader: pops framed bytes from an RX FIFO, writes 32-bit words
// to instruction memory, then releases the CPU reset.
// Ports: clk, rst_n (async, active-low); rx_empty/rx_data in,
// rx_rd out (FWFT FIFO); imem_we/imem_addr/imem_wdata write port;
// busy, boot_done, boot_err, cpu_rst_n status.
// Frame: SYNC_BYTE, N lo, N hi, N*4 payload bytes (LE words).
// Macro BOOT_CHECKSUM_EN: adds a mod-256 payload sum trailer byte.
module boot_ctrl
  import boot_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_empty,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              boot_done,
  output logic              boot_err,
  output logic              cpu_rst_n
);

  localparam int          IDX_W = ADDR_W + 1;
  localparam logic [31:0] MAX_N = 32'(1) << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
  localparam state_e ST_FIN = ST_CSUM;
`else
  localparam state_e ST_FIN = ST_DONE;
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [31:0]      word_q, word_d;
`ifdef BOOT_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;
`endif

  logic             rx_ok;
  logic             pop;
  logic [LEN_W-1:0] len_new;

  // Receiving states may pop; gating with rst_n keeps rx_rd low
  // while reset is held, even with data waiting.
  always_comb begin
    rx_ok = 1'b0;
    unique case (state_q)
      ST_SYNC, ST_LEN_LO,
      ST_LEN_HI, ST_DATA:  rx_ok = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM:             rx_ok = 1'b1;
`endif
      default:             rx_ok = 1'b0;
    endcase
  end

  assign pop   = rx_ok & ~rx_empty & rst_n;
  assign rx_rd = pop;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    len_new = {rx_data, len_q[7:0]};
    unique case (state_q)
      ST_SYNC: begin
        if (pop && rx_data == SYNC_BYTE) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (pop) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (pop) begin
          len_d = len_new;
          if (32'(len_new) > MAX_N) state_d = ST_ERR;
          else if (len_new == '0)   state_d = ST_FIN;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pop) begin
          // Shift in from the top: after 4 bytes byte 0 sits in [7:0].
          word_d = {rx_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q + rx_data;
`endif
          if (bcnt_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (32'(idx_d) < 32'(len_q)) state_d = ST_DATA;
        else                         state_d = ST_FIN;
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (pop) begin
          if (rx_data == csum_q) state_d = ST_DONE;
          else                   state_d = ST_ERR;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = idx_q[ADDR_W-1:0];
  assign imem_wdata = word_q;
  assign boot_done  = (state_q == ST_DONE);
  assign boot_err   = (state_q == ST_ERR);
  assign cpu_rst_n  = boot_done;
  assign busy       = !(state_q == ST_SYNC ||
                        state_q == ST_DONE ||
                        state_q == ST_ERR);

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: default instance (ADDR_W=12) and a
// small instance (ADDR_W=4) sharing one modelled FWFT FIFO.
module tb_boot_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       fifo_empty = 1'b1;
  logic [7:0] head = 8'h00;
  bit         sel = 1'b0;
  logic       rx_empty1, rx_empty2;
  assign rx_empty1 = sel ? 1'b1 : fifo_empty;
  assign rx_empty2 = sel ? fifo_empty : 1'b1;

  logic        rx_rd1, we1, busy1, done1, err1, crn1;
  logic [11:0] addr1;
  logic [31:0] wdata1;
  logic        rx_rd2, we2, busy2, done2, err2, crn2;
  logic [3:0]  addr2;
  logic [31:0] wdata2;

  boot_ctrl dut1 (
    .clk(clk), .rst_n(rst_n),
    .rx_empty(rx_empty1), .rx_data(head), .rx_rd(rx_rd1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .busy(busy1), .boot_done(done1), .boot_err(err1),
    .cpu_rst_n(crn1)
  );

  boot_ctrl #(.ADDR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .rx_empty(rx_empty2), .rx_data(head), .rx_rd(rx_rd2),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .busy(busy2), .boot_done(done2), .boot_err(err2),
    .cpu_rst_n(crn2)
  );

  logic [7:0]  q[$];
  int          gap = 0;
  bit          gap_en = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          viol = 0;
  int          cap_addr[$];
  logic [31:0] cap_data[$];
  int          cap_dut[$];
  logic [31:0] ws[16];

  // FIFO model: pop on the edge where the selected DUT reads.
  always @(posedge clk) begin
    bit p;
    p = sel ? (rx_rd2 && !rx_empty2) : (rx_rd1 && !rx_empty1);
    if (p) begin
      if (q.size() > 0) q.delete(0);
      gap = gap_en ? int'($urandom_range(0, 20)) : 0;
    end else if (gap > 0) begin
      gap--;
    end
    #1;
    fifo_empty = (q.size() == 0) || (gap > 0);
    head = (q.size() > 0) ? q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (rx_rd1 && rx_empty1) viol++;
    if (rx_rd2 && rx_empty2) viol++;
    if (we1) begin
      cap_addr.push_back(int'(addr1));
      cap_data.push_back(wdata1);
      cap_dut.push_back(1);
    end
    if (we2) begin
      cap_addr.push_back(int'(addr2));
      cap_data.push_back(wdata2);
      cap_dut.push_back(2);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    gap_en = 1'b0;
    repeat (2) @(negedge clk);
    cap_addr.delete();
    cap_data.delete();
    cap_dut.delete();
    viol = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_frame(input int n, input bit bad_cs);
    logic [7:0] s;
    logic [7:0] b;
    logic [31:0] w;
    s = 8'h00;
    q.push_back(8'hA5);
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = ws[i];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        q.push_back(b);
        s = s + b;
      end
    end
`ifdef BOOT_CHECKSUM_EN
    q.push_back(bad_cs ? 8'hE5 : s);
`else
    if (bad_cs) s = 8'h00;
`endif
  endtask

  task automatic wait_end(input bit d2, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (d2 ? (done2 || err2) : (done1 || err1)) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout got=none want=done/err");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sel = 1'b0;
    q.delete();
    q.push_back(8'hA5);
    repeat (3) @(negedge clk);
    total++;
    if (rx_rd1 !== 1'b0) begin
      bad++; $display("FAIL rst_rx_rd got=%b want=0", rx_rd1);
    end
    total++;
    if (we1 !== 1'b0) begin
      bad++; $display("FAIL rst_we got=%b want=0", we1);
    end
    total++;
    if (addr1 !== 12'h000) begin
      bad++; $display("FAIL rst_addr got=%h want=000", addr1);
    end
    total++;
    if (wdata1 !== 32'h0) begin
      bad++; $display("FAIL rst_wdata got=%h want=0", wdata1);
    end
    total++;
    if ({busy1, done1, err1, crn1} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_status got=%b want=0000",
               {busy1, done1, err1, crn1});
    end
    total++;
    if (q.size() != 1) begin
      bad++; $display("FAIL rst_nopop got=%0d want=1", q.size());
    end
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    ws[0] = 32'h12345678;
    q.push_back(8'h00);
    push_frame(1, 1'b0);
    wait_end(1'b0, 200, ok);
    total++;
    if (cap_addr.size() != 1) begin
      bad++; $display("FAIL one_cnt got=%0d want=1", cap_addr.size());
    end else begin
      total++;
      if (cap_addr[0] != 0) begin
        bad++; $display("FAIL one_addr got=%0d want=0", cap_addr[0]);
      end
      total++;
      if (cap_data[0] !== 32'h12345678) begin
        bad++;
        $display("FAIL one_data got=%h want=12345678", cap_data[0]);
      end
    end
    total++;
    if ({done1, crn1, err1, busy1} !== 4'b1100) begin
      bad++;
      $display("FAIL one_status got=%b want=1100",
               {done1, crn1, err1, busy1});
    end
    q.push_back(8'hA5);
    q.push_back(8'h01);
    repeat (5) @(negedge clk);
    total++;
    if (q.size() != 2 || rx_rd1 !== 1'b0) begin
      bad++;
      $display("FAIL done_ignore got=%0d/%b want=2/0", q.size(), rx_rd1);
    end
    total++;
    if (done1 !== 1'b1 || crn1 !== 1'b1) begin
      bad++; $display("FAIL done_sticky got=%b%b want=11", done1, crn1);
    end
  endtask

  task automatic test_zero();
    bit ok;
    do_reset();
    push_frame(0, 1'b0);
    wait_end(1'b0, 100, ok);
    total++;
    if (cap_addr.size() != 0) begin
      bad++; $display("FAIL zero_cnt got=%0d want=0", cap_addr.size());
    end
    total++;
    if (done1 !== 1'b1 || err1 !== 1'b0) begin
      bad++; $display("FAIL zero_done got=%b%b want=10", done1, err1);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    do_reset();
    gap_en = 1'b1;
    ws[0] = 32'hDEADBEEF;
    ws[1] = 32'h01020304;
    ws[2] = 32'hA5A50000;
    push_frame(3, 1'b0);
    wait_end(1'b0, 3000, ok);
    total++;
    if (cap_addr.size() != 3) begin
      bad++; $display("FAIL gap_cnt got=%0d want=3", cap_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (cap_addr[i] != i || cap_data[i] !== ws[i]) begin
          bad++;
          $display("FAIL gap_wr%0d got=%0d:%h want=%0d:%h", i,
                   cap_addr[i], cap_data[i], i, ws[i]);
        end
      end
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL gap_rd_empty got=%0d want=0", viol);
    end
    total++;
    if (done1 !== 1'b1) begin
      bad++; $display("FAIL gap_done got=%b want=1", done1);
    end
    gap_en = 1'b0;
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_csum_bad();
    bit ok;
    do_reset();
    ws[0] = 32'h12345678;
    q.push_back(8'h00);
    push_frame(1, 1'b1);
    wait_end(1'b0, 200, ok);
    total++;
    if ({err1, crn1, done1} !== 3'b100) begin
      bad++;
      $display("FAIL cs_err got=%b want=100", {err1, crn1, done1});
    end
    q.push_back(8'hA5);
    q.push_back(8'h00);
    repeat (5) @(negedge clk);
    total++;
    if (q.size() != 2 || rx_rd1 !== 1'b0) begin
      bad++;
      $display("FAIL cs_ignore got=%0d/%b want=2/0", q.size(), rx_rd1);
    end
  endtask
`endif

  task automatic test_overlen();
    bit ok;
    do_reset();
    sel = 1'b1;
    q.push_back(8'hA5);
    q.push_back(8'h11);
    q.push_back(8'h00);
    wait_end(1'b1, 100, ok);
    total++;
    if (err2 !== 1'b1 || crn2 !== 1'b0) begin
      bad++; $display("FAIL len17_err got=%b%b want=10", err2, crn2);
    end
    total++;
    if (cap_addr.size() != 0) begin
      bad++; $display("FAIL len17_nowr got=%0d want=0", cap_addr.size());
    end
  endtask

  task automatic test_full16();
    bit ok;
    do_reset();
    sel = 1'b1;
    for (int i = 0; i < 16; i++) ws[i] = 32'h11111111 * i;
    push_frame(16, 1'b0);
    wait_end(1'b1, 500, ok);
    total++;
    if (done2 !== 1'b1 || err2 !== 1'b0) begin
      bad++; $display("FAIL len16_done got=%b%b want=10", done2, err2);
    end
    total++;
    if (cap_addr.size() != 16) begin
      bad++; $display("FAIL len16_cnt got=%0d want=16", cap_addr.size());
    end else begin
      total++;
      if (cap_addr[15] != 15 || cap_data[15] !== 32'hFFFFFFFF) begin
        bad++;
        $display("FAIL len16_last got=%0d:%h want=15:ffffffff",
                 cap_addr[15], cap_data[15]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    q.push_back(8'hA5);
    q.push_back(8'h01);
    q.push_back(8'h00);
    q.push_back(8'h78);
    q.push_back(8'h56);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (busy1 !== 1'b1) begin
      bad++; $display("FAIL mid_busy got=%b want=1", busy1);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ws[0] = 32'hCAFEF00D;
    ws[1] = 32'h0BADBEEF;
    push_frame(2, 1'b0);
    wait_end(1'b0, 200, ok);
    total++;
    if (cap_addr.size() != 2) begin
      bad++; $display("FAIL mid_cnt got=%0d want=2", cap_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (cap_addr[i] != i || cap_data[i] !== ws[i]) begin
          bad++;
          $display("FAIL mid_wr%0d got=%0d:%h want=%0d:%h", i,
                   cap_addr[i], cap_data[i], i, ws[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_gaps();
`ifdef BOOT_CHECKSUM_EN
    test_csum_bad();
`endif
    test_overlen();
    test_full16();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
